regfile_wr_arbiter: RTL and testbench
=====================================

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter REG_SIZE, default 32: register width in bits.
REQ-002 Parameter RF_SIZE, default 16: number of registers, addressed by 4 bits.
REQ-003 Parameter STARVE_MAX, default 4: number of consecutive denied cycles before a requester is promoted.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 rst  input  1: synchronous reset, active-low, sampled on the rising edge of clk.
REQ-006 ex_valid, ld_valid, dbg_valid  input  1 each: write requests from execute, load and debug.
REQ-007 ex_addr, ld_addr, dbg_addr  input  4 each: destination register index per requester.
REQ-008 ex_data, ld_data, dbg_data  input  REG_SIZE each: write data per requester.
REQ-009 ex_ready, ld_ready, dbg_ready  output  1 each: grant; combinational from the current-cycle valids and starvation state.
REQ-010 rd_addr1, rd_addr2  input  4 each: operand read indices.
REQ-011 rd_data1, rd_data2  output  REG_SIZE each: registered read data.
REQ-012 pos_show  input  4: display register index.
REQ-013 show  output  16: registered bits [15:0] of register[pos_show].
REQ-014 conflict_cnt  output  8: saturating count of cycles with two or more valids.

Function
REQ-015 At most one ready SHALL be high per cycle; a ready SHALL never be high while its valid is low.
REQ-016 When no requester is promoted, priority SHALL be fixed: ex > ld > dbg.
REQ-017 Each requester SHALL own a 3-bit starve counter:
  - +1 (saturating at STARVE_MAX) on each cycle it is valid and not granted.
  - Cleared when it is granted or its valid is low.
REQ-018 A requester whose counter equals STARVE_MAX is promoted and SHALL beat all non-promoted requesters; among promoted requesters, the fixed order ex > ld > dbg SHALL apply.
REQ-019 On a valid&ready cycle, register[addr] SHALL take the data at the clock edge; a handshake with addr 0 SHALL complete but SHALL leave register[0] at 0.
REQ-020 Requesters SHALL hold valid/addr/data stable until ready; the block SHALL NOT queue requests, so a denied request is retried by its owner holding valid.
REQ-021 rd_data1/rd_data2 SHALL update one cycle after the address is presented (latency 1).
REQ-022 A read of the address being written in the same cycle SHALL return the new write data (write-through bypass); address 0 SHALL always return 0.
REQ-023 show SHALL have latency 1 and the same bypass as REQ-022.
REQ-024 conflict_cnt SHALL increment on each cycle with two or more valids high and SHALL hold at 255.
REQ-025 With no valid high, all readys SHALL be low and the register file SHALL be unchanged.

Reset
REQ-026 When rst=0 at a clock edge:
  - register[0]=0; register[k]=k*16 for k=1..14; register[15]=0.
  - rd_data1, rd_data2, show and conflict_cnt are 0; all starve counters are 0.
REQ-027 Readys SHALL be forced low while rst=0, and any handshake in a reset cycle SHALL be discarded.
REQ-028 Reset asserted with requests pending SHALL take precedence; arbitration SHALL resume from the cleared state on the first cycle with rst=1.

Verification
REQ-029 Release reset, set rd_addr1=5, rd_addr2=15, pos_show=14 -> next cycle rd_data1=80, rd_data2=0, show=224.
REQ-030 Same cycle: ex_valid (addr 3, data 0xAAAA), ld_valid (addr 4, data 0x5555) -> ex_ready=1, ld_ready=0, conflict_cnt=1; the following cycle ld_ready=1 and register[4]=0x5555.
REQ-031 Hold ex_valid and dbg_valid (dbg addr 7, data 0x1234) continuously -> dbg granted on the 5th cycle (counter reached 4), ex granted the cycle after, register[7]=0x1234.
REQ-032 ld_valid with addr 0, data 0xFFFF -> ld_ready=1 and a read of address 0 returns 0.
REQ-033 ex writes addr 9, data 0xBEEF while rd_addr1=9 -> next cycle rd_data1=0xBEEF; assert rst=0 mid-run -> register[9] returns to 144 and conflict_cnt=0.

Source files
------------

// File: rtl/regfile_wr_arbiter_if.sv
// Bundle of the write-request, read-port and status signals of the
// register-file write arbiter. The master side is the requesters plus the
// operand/display readers; the slave side is the arbiter itself.
interface regfile_wr_arbiter_if #(
  parameter int REG_SIZE = 32
);
  logic                ex_valid, ld_valid, dbg_valid;
  logic [3:0]          ex_addr, ld_addr, dbg_addr;
  logic [REG_SIZE-1:0] ex_data, ld_data, dbg_data;
  logic                ex_ready, ld_ready, dbg_ready;
  logic [3:0]          rd_addr1, rd_addr2;
  logic [REG_SIZE-1:0] rd_data1, rd_data2;
  logic [3:0]          pos_show;
  logic [15:0]         show;
  logic [7:0]          conflict_cnt;

  modport master (
    output ex_valid, ld_valid, dbg_valid,
    output ex_addr, ld_addr, dbg_addr,
    output ex_data, ld_data, dbg_data,
    output rd_addr1, rd_addr2, pos_show,
    input  ex_ready, ld_ready, dbg_ready,
    input  rd_data1, rd_data2, show, conflict_cnt
  );

  modport slave (
    input  ex_valid, ld_valid, dbg_valid,
    input  ex_addr, ld_addr, dbg_addr,
    input  ex_data, ld_data, dbg_data,
    input  rd_addr1, rd_addr2, pos_show,
    output ex_ready, ld_ready, dbg_ready,
    output rd_data1, rd_data2, show, conflict_cnt
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Register file with a three-way write arbiter (execute, load, debug).
// Fixed priority ex > ld > dbg, with starvation promotion after STARVE_MAX
// consecutive denied cycles. Two registered read ports and a 16-bit display
// port, all with write-through bypass. Register 0 always reads as zero.
module regfile_wr_arbiter #(
  parameter int REG_SIZE   = 32,
  parameter int RF_SIZE    = 16,
  parameter int STARVE_MAX = 4
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wr_arbiter_if.slave bus
);

  // Requester index 0 = ex, 1 = ld, 2 = dbg; lower index wins ties.
  logic [2:0]          w_valid;
  logic [3:0]          w_addr  [3];
  logic [REG_SIZE-1:0] w_data  [3];
  logic [2:0]          w_promoted;
  logic [2:0]          w_grant;
  logic                w_wr_en;
  logic [3:0]          w_wr_addr;
  logic [REG_SIZE-1:0] w_wr_data;
  logic [REG_SIZE-1:0] w_rd1, w_rd2;
  logic [15:0]         w_show;
  logic                w_multi;

  logic [2:0]          r_starve [3];
  logic [REG_SIZE-1:0] r_regs   [RF_SIZE];
  logic [REG_SIZE-1:0] r_rd_data1, r_rd_data2;
  logic [15:0]         r_show;
  logic [7:0]          r_conflict_cnt;

  assign w_valid   = {bus.dbg_valid, bus.ld_valid, bus.ex_valid};
  assign w_addr[0] = bus.ex_addr;
  assign w_addr[1] = bus.ld_addr;
  assign w_addr[2] = bus.dbg_addr;
  assign w_data[0] = bus.ex_data;
  assign w_data[1] = bus.ld_data;
  assign w_data[2] = bus.dbg_data;

  // One-hot of the lowest set bit: implements the ex > ld > dbg order.
  function automatic logic [2:0] first_set(input logic [2:0] v);
    first_set = 3'b000;
    if (v[0])      first_set = 3'b001;
    else if (v[1]) first_set = 3'b010;
    else if (v[2]) first_set = 3'b100;
  endfunction

  // Grant: promoted requesters beat everyone else; readys stay low in reset.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_promoted = 3'b000;
    w_grant    = 3'b000;
    for (int i = 0; i < 3; i++)
      w_promoted[i] = w_valid[i] && (r_starve[i] == 3'(STARVE_MAX));
    if (rst)
      w_grant = (|w_promoted) ? first_set(w_promoted) : first_set(w_valid);
  end

  assign bus.ex_ready  = w_grant[0];
  assign bus.ld_ready  = w_grant[1];
  assign bus.dbg_ready = w_grant[2];

  // Select the granted write; a handshake to address 0 completes but writes nothing.
  always_comb begin
    w_wr_addr = '0;
    w_wr_data = '0;
    for (int i = 0; i < 3; i++) begin
      if (w_grant[i]) begin
        w_wr_addr = w_addr[i];
        w_wr_data = w_data[i];
      end
    end
    w_wr_en = (|w_grant) && (w_wr_addr != 4'd0);
  end

  assign w_multi = (w_valid[0] & w_valid[1]) | (w_valid[0] & w_valid[2]) |
                   (w_valid[1] & w_valid[2]);

  // Read paths with write-through bypass; address 0 is forced to zero.
  assign w_rd1  = (bus.rd_addr1 == 4'd0) ? '0 :
                  (w_wr_en && w_wr_addr == bus.rd_addr1) ? w_wr_data : r_regs[bus.rd_addr1];
  assign w_rd2  = (bus.rd_addr2 == 4'd0) ? '0 :
                  (w_wr_en && w_wr_addr == bus.rd_addr2) ? w_wr_data : r_regs[bus.rd_addr2];
  assign w_show = (bus.pos_show == 4'd0) ? 16'd0 :
                  (w_wr_en && w_wr_addr == bus.pos_show) ? w_wr_data[15:0] :
                                                           r_regs[bus.pos_show][15:0];

  // Starve counters: count denied-while-valid cycles, saturate, clear on grant or idle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst)                           r_starve[i] <= 3'd0;
      else if (!w_valid[i] || w_grant[i]) r_starve[i] <= 3'd0;
      else if (r_starve[i] != 3'(STARVE_MAX))
        r_starve[i] <= r_starve[i] + 3'd1;
    end
  end

  // Register array: loads the k*16 pattern on reset, otherwise takes the granted write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the array is reset on purpose here -- software relies on the k*16 boot pattern.
      for (int k = 0; k < RF_SIZE; k++)
        r_regs[k] <= (k == 0 || k == RF_SIZE - 1) ? '0 : REG_SIZE'(k * 16);
    end else if (w_wr_en) begin
      r_regs[w_wr_addr] <= w_wr_data;
    end
  end

  // Registered read, display and saturating conflict counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_data1     <= '0;
      r_rd_data2     <= '0;
      r_show         <= '0;
      r_conflict_cnt <= '0;
    end else begin
      r_rd_data1 <= w_rd1;
      r_rd_data2 <= w_rd2;
      r_show     <= w_show;
      if (w_multi && r_conflict_cnt != 8'hFF)
        r_conflict_cnt <= r_conflict_cnt + 8'd1;
    end
  end

  assign bus.rd_data1     = r_rd_data1;
  assign bus.rd_data2     = r_rd_data2;
  assign bus.show         = r_show;
  assign bus.conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed testbench for regfile_wr_arbiter: reset values, fixed priority,
// starvation promotion, address-0 writes, bypass, conflict saturation, reset.
module tb_regfile_wr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  regfile_wr_arbiter_if #(.REG_SIZE(32)) bus ();

  regfile_wr_arbiter #(.REG_SIZE(32), .RF_SIZE(16), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ex_valid  = 1'b0; bus.ld_valid = 1'b0; bus.dbg_valid = 1'b0;
    bus.ex_addr   = 4'd0; bus.ld_addr  = 4'd0; bus.dbg_addr  = 4'd0;
    bus.ex_data   = '0;   bus.ld_data  = '0;   bus.dbg_data  = '0;
    bus.rd_addr1  = 4'd0; bus.rd_addr2 = 4'd0; bus.pos_show  = 4'd0;
  endtask

  // Readys as {ex,ld,dbg}, checked after inputs have settled.
  task automatic chk_ready(input string name, input logic [2:0] exp);
    logic [2:0] got;
    #1;
    got = {bus.ex_ready, bus.ld_ready, bus.dbg_ready};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: ready{ex,ld,dbg} got=%b expected=%b", name, got, exp);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    bus.ex_valid = 1'b1; bus.ex_addr = 4'd5; bus.ex_data = 32'hDEAD;
    bus.rd_addr1 = 4'd5; bus.pos_show = 4'd5;
    chk_ready("reset_ready_forced_low", 3'b000);
    step(); step();
    checks++;
    if (bus.rd_data1 !== 32'd0 || bus.show !== 16'd0 || bus.conflict_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs: rd1=%0h show=%0h cc=%0d expected 0/0/0",
               bus.rd_data1, bus.show, bus.conflict_cnt);
    end
    idle_inputs();
    rst = 1'b1;
    chk_ready("idle_no_ready", 3'b000);
  endtask

  task automatic test_reset_values();
    bus.rd_addr1 = 4'd5; bus.rd_addr2 = 4'd15; bus.pos_show = 4'd14;
    step();
    checks++;
    if (bus.rd_data1 !== 32'd80 || bus.rd_data2 !== 32'd0 || bus.show !== 16'd224) begin
      failures++;
      $display("FAIL reset_pattern: rd1=%0d rd2=%0d show=%0d expected 80/0/224",
               bus.rd_data1, bus.rd_data2, bus.show);
    end
    // The ex write to 5 during reset must have been discarded.
    for (int k = 1; k < 15; k += 4) begin
      bus.rd_addr1 = 4'(k);
      step();
      checks++;
      if (bus.rd_data1 !== 32'(k * 16)) begin
        failures++;
        $display("FAIL reset_reg%0d: got=%0d expected=%0d", k, bus.rd_data1, k * 16);
      end
    end
  endtask

  task automatic test_priority_conflict();
    bus.ex_valid = 1'b1; bus.ex_addr = 4'd3; bus.ex_data = 32'hAAAA;
    bus.ld_valid = 1'b1; bus.ld_addr = 4'd4; bus.ld_data = 32'h5555;
    bus.rd_addr1 = 4'd4;
    chk_ready("conflict_ex_wins", 3'b100);
    step();
    checks++;
    if (bus.conflict_cnt !== 8'd1) begin
      failures++;
      $display("FAIL conflict_cnt_1: got=%0d expected=1", bus.conflict_cnt);
    end
    bus.ex_valid = 1'b0;
    chk_ready("ld_after_ex", 3'b010);
    step();
    checks++;
    if (bus.rd_data1 !== 32'h5555) begin
      failures++;
      $display("FAIL ld_write_bypass: got=%0h expected=5555", bus.rd_data1);
    end
    bus.ld_valid = 1'b0;
    bus.rd_addr1 = 4'd3; bus.rd_addr2 = 4'd4;
    step();
    checks++;
    if (bus.rd_data1 !== 32'hAAAA || bus.rd_data2 !== 32'h5555 || bus.conflict_cnt !== 8'd1) begin
      failures++;
      $display("FAIL stored_writes: rd1=%0h rd2=%0h cc=%0d expected AAAA/5555/1",
               bus.rd_data1, bus.rd_data2, bus.conflict_cnt);
    end
  endtask

  task automatic test_starvation();
    logic [2:0] exp;
    bus.ex_valid  = 1'b1; bus.ex_addr  = 4'd2; bus.ex_data  = 32'h1111;
    bus.dbg_valid = 1'b1; bus.dbg_addr = 4'd7; bus.dbg_data = 32'h1234;
    for (int c = 1; c <= 6; c++) begin
      exp = (c == 5) ? 3'b001 : 3'b100;
      chk_ready($sformatf("starve_ex_dbg_cycle%0d", c), exp);
      step();
    end
    idle_inputs();
    bus.rd_addr1 = 4'd7; bus.rd_addr2 = 4'd2;
    step();
    checks++;
    if (bus.rd_data1 !== 32'h1234 || bus.rd_data2 !== 32'h1111 || bus.conflict_cnt !== 8'd7) begin
      failures++;
      $display("FAIL starve_result: rd1=%0h rd2=%0h cc=%0d expected 1234/1111/7",
               bus.rd_data1, bus.rd_data2, bus.conflict_cnt);
    end
  endtask

  // All three held: ld and dbg both reach the limit together, ld first, then
  // dbg (its counter stays saturated), then ex again.
  task automatic test_three_way_starvation();
    logic [2:0] exp_seq [7];
    exp_seq = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b010, 3'b001, 3'b100};
    bus.ex_valid  = 1'b1; bus.ex_addr  = 4'd10; bus.ex_data  = 32'hE0;
    bus.ld_valid  = 1'b1; bus.ld_addr  = 4'd11; bus.ld_data  = 32'hE1;
    bus.dbg_valid = 1'b1; bus.dbg_addr = 4'd12; bus.dbg_data = 32'hE2;
    for (int c = 0; c < 7; c++) begin
      chk_ready($sformatf("starve3_cycle%0d", c + 1), exp_seq[c]);
      step();
    end
    idle_inputs();
    bus.rd_addr1 = 4'd11; bus.rd_addr2 = 4'd12;
    step();
    checks++;
    if (bus.rd_data1 !== 32'hE1 || bus.rd_data2 !== 32'hE2 || bus.conflict_cnt !== 8'd14) begin
      failures++;
      $display("FAIL starve3_result: rd1=%0h rd2=%0h cc=%0d expected E1/E2/14",
               bus.rd_data1, bus.rd_data2, bus.conflict_cnt);
    end
  endtask

  task automatic test_addr_zero();
    bus.ld_valid = 1'b1; bus.ld_addr = 4'd0; bus.ld_data = 32'hFFFF;
    bus.rd_addr1 = 4'd0; bus.pos_show = 4'd0;
    chk_ready("addr0_handshake", 3'b010);
    step();
    checks++;
    if (bus.rd_data1 !== 32'd0 || bus.show !== 16'd0) begin
      failures++;
      $display("FAIL addr0_bypass: rd1=%0h show=%0h expected 0/0", bus.rd_data1, bus.show);
    end
    bus.ld_valid = 1'b0;
    step();
    checks++;
    if (bus.rd_data1 !== 32'd0) begin
      failures++;
      $display("FAIL addr0_stored: got=%0h expected=0", bus.rd_data1);
    end
  endtask

  task automatic test_conflict_saturate();
    bus.ex_valid = 1'b1; bus.ld_valid = 1'b1;
    for (int c = 0; c < 260; c++) step();
    idle_inputs();
    checks++;
    if (bus.conflict_cnt !== 8'd255) begin
      failures++;
      $display("FAIL conflict_saturate: got=%0d expected=255", bus.conflict_cnt);
    end
  endtask

  task automatic test_bypass_and_reset();
    bus.ex_valid = 1'b1; bus.ex_addr = 4'd9; bus.ex_data = 32'hBEEF;
    bus.rd_addr1 = 4'd9; bus.pos_show = 4'd9;
    chk_ready("ex_write9", 3'b100);
    step();
    checks++;
    if (bus.rd_data1 !== 32'hBEEF || bus.show !== 16'hBEEF) begin
      failures++;
      $display("FAIL bypass9: rd1=%0h show=%0h expected BEEF/BEEF", bus.rd_data1, bus.show);
    end
    // Reset with a request pending: ready must drop, write must be lost.
    bus.ex_data = 32'h7777;
    rst = 1'b0;
    chk_ready("reset_pending_ready", 3'b000);
    step();
    checks++;
    if (bus.conflict_cnt !== 8'd0 || bus.rd_data1 !== 32'd0) begin
      failures++;
      $display("FAIL midrun_reset: cc=%0d rd1=%0h expected 0/0", bus.conflict_cnt, bus.rd_data1);
    end
    bus.ex_valid = 1'b0;
    rst = 1'b1;
    step();
    checks++;
    if (bus.rd_data1 !== 32'd144 || bus.show !== 16'd144) begin
      failures++;
      $display("FAIL reg9_restored: rd1=%0d show=%0d expected 144/144", bus.rd_data1, bus.show);
    end
    // Arbitration restarts clean: ld beats dbg by fixed order.
    bus.ld_valid = 1'b1; bus.dbg_valid = 1'b1;
    chk_ready("post_reset_fixed_order", 3'b010);
    step();
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_reset_values();
    test_priority_conflict();
    test_starvation();
    test_three_way_starvation();
    test_addr_zero();
    test_conflict_saturate();
    test_bypass_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
